muldiv_iter: RTL
================

Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide execution unit. Sits directly downstream of the register file read ports, in parallel with the ALU.
- Consumes rs1/rs2 operand values and produces a 32-bit result for the register-file write-data mux.
- Asserts busy so the core stalls PC and regfile write-enable until done.
- Fixed latency; one radix-2 iteration per clock.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clock clk
start  input  1  request; sampled only in IDLE or DONE
funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1  input  XLEN  operand A (multiplicand/dividend), from regfile rs1
rs2  input  XLEN  operand B (multiplier/divisor), from regfile rs2
busy  output  1  high while computing; core holds instruction and suppresses regfile we
done  output  1  one-cycle pulse; result valid; core asserts regfile we this cycle
result  output  XLEN  registered result; held until the next accepted start or reset

Behaviour:
- Reset (sync, any state, including mid-operation): state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0. An in-flight operation is aborted with no done pulse.
- States:
  - IDLE: start=1 -> CALC.
  - CALC: counter increments each edge. After the XLEN-th iteration -> DONE.
  - DONE: start=1 -> CALC (back-to-back accepted); else -> IDLE.
- Accept edge: funct3 is latched, along with the rs1/rs2 magnitudes and sign flags. Later changes to the inputs are ignored.
  - Signed operands: MULH, DIV, REM (both operands); MULHSU (rs1 only).
  - Magnitude = two's-complement negation if the operand is signed and negative.
- Latency: start sampled at edge E; busy=1 from after E through edge E+XLEN; done=1 and result valid in the cycle after edge E+XLEN. Total XLEN+1 cycles from start to done.
- busy and done are never high together. start in CALC is ignored.
- Multiply:
  - Unsigned shift-add of magnitudes into a 2*XLEN product.
  - Negate the product if sign(A) XOR sign(B), considering only signed operands.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - MUL low bits are identical for signed/unsigned interpretation.
- Divide:
  - Restoring division on magnitudes; one quotient bit per iteration, MSB first.
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A) (signed ops only).
- Divide by zero (rs2=0), with normal full latency:
  - DIV/DIVU -> 0xFFFFFFFF.
  - REM/REMU -> rs1 value as latched.
- Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0x00000000. Full latency.
- Sign correction and special-case selection are applied on the edge entering DONE; result is a flop, never combinational from inputs.
- result is stable from DONE until the next accepted start. After a new start it may change freely; consumers use it only when done=1.
- Reset and start asserted on the same edge: reset wins.

Test Plan:
- MULHU 0xFFFFFFFF x 0xFFFFFFFF; MUL 7 x -3 -> MULHU done after exactly 33 cycles, result 0xFFFFFFFE. MUL result 0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF(-1) x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000005/0 -> 0x80000005. Overflow: DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Handshake: start held high in CALC has no effect; start in the DONE cycle launches a second op, and its done arrives 33 cycles later. Operands changed after the accept edge do not alter the result.
- Reset asserted at iteration 10: next cycle busy=0, done=0, result=0. No done pulse ever appears for the aborted op. A fresh start then completes normally.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per clock, fixed XLEN+1 cycle latency from accepted start to done.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic            b_zero_q, b_zero_d, ovf_q, ovf_d;
  logic [XLEN-1:0] rs1_q, rs1_d, opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, result_q, result_d;

  logic            accept, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in, is_div_in, last_iter, div_ok, neg_p;
  logic [XLEN-1:0] mag_a, mag_b, mul_hi, mul_lo, div_hi, div_lo, hi_n, lo_n, quot, rem;
  logic [XLEN:0]   mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] prod, prod_s;

  // Handshake: start is a request honoured only in IDLE or DONE (busy=0); the op is taken on
  // that edge, and done pulses for exactly one cycle when result becomes valid.
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sgn_a_in  = funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
  assign sgn_b_in  = funct3 inside {3'd1, 3'd4, 3'd6};
  assign neg_a_in  = sgn_a_in && rs1[XLEN-1];
  assign neg_b_in  = sgn_b_in && rs2[XLEN-1];
  assign mag_a     = neg_a_in ? -rs1 : rs1;
  assign mag_b     = neg_b_in ? -rs2 : rs2;
  assign is_div_in = funct3[2];
  assign last_iter = (state_q == S_CALC) && (cnt_q == LAST);

  // Multiply keeps {hi,lo} as the product/multiplier pair; divide keeps hi=remainder, lo=quotient.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi    = mul_sum[XLEN:1];
  assign mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_trial[XLEN];
  assign div_hi    = div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_lo    = {lo_q[XLEN-2:0], div_ok};
  assign hi_n      = op_q[2] ? div_hi : mul_hi;
  assign lo_n      = op_q[2] ? div_lo : mul_lo;

  assign neg_p  = neg_a_q ^ neg_b_q;
  assign prod   = {hi_n, lo_n};
  assign prod_s = neg_p ? -prod : prod;
  assign quot   = neg_p ? -lo_n : lo_n;
  assign rem    = neg_a_q ? -hi_n : hi_n;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_zero_d = b_zero_q;
    ovf_d    = ovf_q;
    rs1_d    = rs1_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? S_CALC : S_IDLE;
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        hi_d  = hi_n;
        lo_d  = lo_n;
        if (last_iter) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      cnt_d    = '0;
      op_d     = funct3;
      neg_a_d  = neg_a_in;
      neg_b_d  = neg_b_in;
      b_zero_d = (rs2 == '0);
      ovf_d    = (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
      rs1_d    = rs1;
      opnd_d   = is_div_in ? mag_b : mag_a;
      hi_d     = '0;
      lo_d     = is_div_in ? mag_a : mag_b;
    end
    if (last_iter) begin
      case (op_q)
        3'd0:    result_d = prod_s[XLEN-1:0];
        3'd4:    result_d = b_zero_q ? '1 : (ovf_q ? {1'b1, {(XLEN-1){1'b0}}} : quot);
        3'd5:    result_d = b_zero_q ? '1 : lo_n;
        3'd6:    result_d = b_zero_q ? rs1_q : (ovf_q ? '0 : rem);
        3'd7:    result_d = b_zero_q ? rs1_q : hi_n;
        default: result_d = prod_s[2*XLEN-1:XLEN];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      ovf_q    <= 1'b0;
      rs1_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_zero_q <= b_zero_d;
      ovf_q    <= ovf_d;
      rs1_q    <= rs1_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q == S_CALC);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
